// File: rtl/raster_pkg.sv
// Shared types and constants for the raster pattern generator.
// Latency: n/a (types only).
// Backpressure: n/a.
package raster_pkg;

    localparam int PIX_W = 24;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_GRADIENT = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_BARS     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Colour-bar order, left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam pix_t BAR_LUT [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/raster_pattern_gen_if.sv
// Pixel stream bundle: RGB pixel, coordinates, frame markers, valid/ready.
// Latency: n/a (wiring only).
// Backpressure: master holds all fields while valid && !ready.
interface raster_pattern_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    import raster_pkg::*;

    pix_t           pixel;
    logic [X_W-1:0] counterX;
    logic [Y_W-1:0] counterY;
    logic           valid;
    logic           ready;
    logic           sof;
    logic           eol;
    logic           eof;

    modport master (output pixel, counterX, counterY, valid, sof, eol, eof, input ready);
    modport slave  (input pixel, counterX, counterY, valid, sof, eol, eof, output ready);

endinterface

// File: rtl/raster_pattern_lut.sv
// Combinational test-pattern pixel from mode, colour, coordinates and bar index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
module raster_pattern_lut
    import raster_pkg::*;
#(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int CHECK_SHIFT = 4
) (
    input  mode_t          mode,
    input  pix_t           color,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [2:0]     bar,
    output pix_t           pixel
);

    logic [7:0] x8;
    logic [7:0] y8;
    logic       xb;
    logic       yb;

    // Gradient uses the low byte of each coordinate, zero-extended on narrow counters.
    assign x8 = 8'(x);
    assign y8 = 8'(y);
    assign xb = |((x >> CHECK_SHIFT) & X_W'(1));
    assign yb = |((y >> CHECK_SHIFT) & Y_W'(1));

    always_comb begin
        pixel = '0;
        case (mode)
            MODE_SOLID:    pixel = color;
            MODE_GRADIENT: pixel = {x8, y8, 8'h00};
            MODE_CHECKER:  pixel = (xb ^ yb) ? color : '0;
            MODE_BARS:     pixel = BAR_LUT[bar];
            default:       pixel = '0;
        endcase
    end

endmodule

// File: rtl/raster_pattern_gen.sv
// Row-major raster scanner emitting one registered test-pattern pixel per transfer; RASTER_LOOP_EN makes frames repeat.
// Latency: first pixel (0,0) valid on the edge after start is accepted; then one pixel per valid&&ready.
// Backpressure: pixel/coords/markers frozen while valid&&!ready; only abort may drop valid mid-frame.
module raster_pattern_gen
    import raster_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int CHECK_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [1:0]                  mode,
    input  pix_t                        color,
    output logic                        busy,
    output logic                        done,
    raster_pattern_gen_if.master        pix_if
);

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [X_W-1:0] BAR_LAST = X_W'(H_ACTIVE / 8 - 1);

    state_t         state, state_nx;
    logic [X_W-1:0] x_q, x_nx, bcnt_q, bcnt_nx;
    logic [Y_W-1:0] y_q, y_nx;
    logic [2:0]     bar_q, bar_nx;
    mode_t          mode_q, mode_nx;
    pix_t           color_q, color_nx, pix_q, pix_nx;
    logic           valid_q, valid_nx, done_q, done_nx;
    logic           sof_q, eol_q, eof_q;
    logic           load, clear, xfer, last;

    assign xfer = valid_q && pix_if.ready;
    assign last = (x_q == X_LAST) && (y_q == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        x_nx     = x_q;
        y_nx     = y_q;
        bar_nx   = bar_q;
        bcnt_nx  = bcnt_q;
        mode_nx  = mode_q;
        color_nx = color_q;
        valid_nx = valid_q;
        done_nx  = done_q;
        load     = 1'b0;
        clear    = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            done_nx  = 1'b0;
            x_nx     = '0;
            y_nx     = '0;
            clear    = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nx = RUN;
                        valid_nx = 1'b1;
                        done_nx  = 1'b0;
                        x_nx     = '0;
                        y_nx     = '0;
                        bar_nx   = '0;
                        bcnt_nx  = BAR_LAST;
                        mode_nx  = mode_t'(mode);
                        color_nx = color;
                        load     = 1'b1;
                    end
                end
                RUN: begin
`ifdef RASTER_LOOP_EN
                    done_nx = 1'b0;
`endif
                    if (xfer) begin
                        if (last) begin
`ifdef RASTER_LOOP_EN
                            // Wrap straight into the next frame with freshly latched settings.
                            done_nx  = 1'b1;
                            x_nx     = '0;
                            y_nx     = '0;
                            bar_nx   = '0;
                            bcnt_nx  = BAR_LAST;
                            mode_nx  = mode_t'(mode);
                            color_nx = color;
                            load     = 1'b1;
`else
                            state_nx = DONE;
                            valid_nx = 1'b0;
                            done_nx  = 1'b1;
                            x_nx     = '0;
                            y_nx     = '0;
                            clear    = 1'b1;
`endif
                        end else if (x_q == X_LAST) begin
                            x_nx    = '0;
                            y_nx    = y_q + Y_W'(1);
                            bar_nx  = '0;
                            bcnt_nx = BAR_LAST;
                            load    = 1'b1;
                        end else begin
                            x_nx = x_q + X_W'(1);
                            load = 1'b1;
                            if (bcnt_q == '0) begin
                                bar_nx  = bar_q + 3'd1;
                                bcnt_nx = BAR_LAST;
                            end else begin
                                bcnt_nx = bcnt_q - X_W'(1);
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    raster_pattern_lut #(
        .X_W         (X_W),
        .Y_W         (Y_W),
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_lut (
        .mode  (mode_nx),
        .color (color_nx),
        .x     (x_nx),
        .y     (y_nx),
        .bar   (bar_nx),
        .pixel (pix_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            bar_q   <= '0;
            bcnt_q  <= '0;
            mode_q  <= MODE_SOLID;
            color_q <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            x_q     <= x_nx;
            y_q     <= y_nx;
            bar_q   <= bar_nx;
            bcnt_q  <= bcnt_nx;
            mode_q  <= mode_nx;
            color_q <= color_nx;
            valid_q <= valid_nx;
            done_q  <= done_nx;
            if (load) begin
                pix_q <= pix_nx;
                sof_q <= (x_nx == '0) && (y_nx == '0);
                eol_q <= (x_nx == X_LAST);
                eof_q <= (x_nx == X_LAST) && (y_nx == Y_LAST);
            end else if (clear) begin
                sof_q <= 1'b0;
                eol_q <= 1'b0;
                eof_q <= 1'b0;
            end
        end
    end

    assign pix_if.pixel    = pix_q;
    assign pix_if.counterX = x_q;
    assign pix_if.counterY = y_q;
    assign pix_if.valid    = valid_q;
    assign pix_if.sof      = sof_q;
    assign pix_if.eol      = eol_q;
    assign pix_if.eof      = eof_q;
    assign busy            = (state == RUN);
    assign done            = done_q;

endmodule
